// File: rtl/cosim_xor_misr.sv
// cosim_xor_misr: folds each WIDTH-bit result vector to SIG_WIDTH bits by XOR
// and compacts NVEC folded values into a MISR signature, handed off over a
// sig_valid/sig_ack handshake.
module cosim_xor_misr #(
  parameter int                   WIDTH     = 128,
  parameter int                   SIG_WIDTH = 32,
  parameter int                   NVEC      = 16,
  parameter logic [SIG_WIDTH-1:0] POLY      = 32'h8000_0062,
  parameter logic [SIG_WIDTH-1:0] SEED      = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         sig_valid,
  input  logic                         sig_ack,
  output logic [SIG_WIDTH-1:0]         sig_data,
  output logic                         busy,
  output logic [$clog2(NVEC+1)-1:0]    count
);

  localparam int NSL = WIDTH / SIG_WIDTH;
  localparam int CW  = $clog2(NVEC + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t               r_state;
  logic [SIG_WIDTH-1:0] r_sig;
  logic [CW-1:0]        r_count;
  logic                 r_in_ready;
  logic                 r_busy;
  logic                 r_sig_valid;

  // XOR fold as a chain across the slices; slice 0 sits at the LSBs.
  logic [NSL:0][SIG_WIDTH-1:0] w_fold_chain;
  logic [SIG_WIDTH-1:0]        w_fold;
  logic                        w_fb;
  logic [SIG_WIDTH-1:0]        w_misr;
  logic                        w_accept;
  logic                        w_last;

  assign w_fold_chain[0] = '0;
  for (genvar g = 0; g < NSL; g++) begin : g_fold
    assign w_fold_chain[g+1] = w_fold_chain[g] ^ in_data[g*SIG_WIDTH +: SIG_WIDTH];
  end
  assign w_fold = w_fold_chain[NSL];

  // Feedback is the parity of the tapped bits; the shift drops the MSB.
  assign w_fb     = ^(r_sig & POLY);
  assign w_misr   = {r_sig[SIG_WIDTH-2:0], w_fb} ^ w_fold;
  assign w_accept = in_valid && r_in_ready;
  assign w_last   = (r_count == CW'(NVEC - 1));

  // Control FSM; Moore outputs are registered next to the state so they
  // always match the state they decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_sig       <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_sig_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_ACCUM;
            r_sig      <= SEED;
            r_count    <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_sig   <= w_misr;
            r_count <= r_count + 1'b1;
            if (w_last) begin
              r_state     <= S_DONE;
              r_in_ready  <= 1'b0;
              r_busy      <= 1'b0;
              r_sig_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          // start alongside ack is dropped; a fresh start is needed in IDLE.
          if (sig_ack) begin
            r_state     <= S_IDLE;
            r_sig_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b0;
          r_busy      <= 1'b0;
          r_sig_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign sig_valid = r_sig_valid;
  assign sig_data  = r_sig;
  assign count     = r_count;

endmodule

// File: tb/tb_cosim_xor_misr.sv
// Bench for cosim_xor_misr: four instances (NVEC = 1, 2, 4, 16) share one
// stimulus stream; a list-based signature model checks every output of every
// instance each cycle, and directed literals pin the model.
module tb_cosim_xor_misr;

  localparam int NI = 4;
  localparam int NVS [NI] = '{1, 2, 4, 16};
  localparam logic [31:0] POLY = 32'h8000_0062;
  localparam logic [31:0] SEED = 32'h0;

  logic         clk;
  logic         reset, start, in_valid, sig_ack;
  logic [127:0] in_data;

  logic        rdy [NI];
  logic        sv  [NI];
  logic        bsy [NI];
  logic [31:0] sig [NI];
  logic [4:0]  cnt [NI];

  int nchecks = 0;
  int nerrors = 0;
  bit chk_en  = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [$clog2(NVS[g]+1)-1:0] c;
    cosim_xor_misr #(.WIDTH(128), .SIG_WIDTH(32), .NVEC(NVS[g]),
                     .POLY(POLY), .SEED(SEED)) u_dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
      .in_ready(rdy[g]), .in_data(in_data), .sig_valid(sv[g]),
      .sig_ack(sig_ack), .sig_data(sig[g]), .busy(bsy[g]), .count(c));
    assign cnt[g] = 5'(c);
  end

  // ---------------- behavioural model ----------------
  // Phase 0 idle, 1 collecting, 2 holding a finished signature.
  // The signature is never stored: it is replayed from the base value over
  // the list of folded vectors accepted so far.
  int          ph    [NI];
  int          mn    [NI];
  logic [31:0] mbase [NI];
  logic [31:0] mv    [NI][16];

  function automatic logic [31:0] fold128(input logic [127:0] d);
    logic [127:0] v = d;
    logic [31:0]  f = 0;
    for (int k = 0; k < 4; k++) begin
      f = f ^ v[31:0];
      v = v >> 32;
    end
    return f;
  endfunction

  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] f);
    logic fb = 1'($countones(s & POLY) % 2);
    return ((s << 1) | 32'(fb)) ^ f;
  endfunction

  function automatic logic [31:0] msig(input int i);
    logic [31:0] s = mbase[i];
    for (int k = 0; k < mn[i]; k++) s = misr_step(s, mv[i][k]);
    return s;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        ph[i] <= 0; mn[i] <= 0; mbase[i] <= 32'h0;
      end else if (ph[i] == 0) begin
        if (start) begin ph[i] <= 1; mn[i] <= 0; mbase[i] <= SEED; end
      end else if (ph[i] == 1) begin
        if (in_valid) begin
          mv[i][mn[i]] <= fold128(in_data);
          mn[i] <= mn[i] + 1;
          if (mn[i] + 1 == NVS[i]) ph[i] <= 2;
        end
      end else if (sig_ack) begin
        ph[i] <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("in_ready[%0d]", i),  32'(rdy[i]), 32'(ph[i] == 1));
        chk($sformatf("busy[%0d]", i),      32'(bsy[i]), 32'(ph[i] == 1));
        chk($sformatf("sig_valid[%0d]", i), 32'(sv[i]),  32'(ph[i] == 2));
        chk($sformatf("count[%0d]", i),     32'(cnt[i]), 32'(mn[i]));
        chk($sformatf("sig_data[%0d]", i),  sig[i],      msig(i));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; tick(); reset = 0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] d5 [4];
  logic [31:0]  ref5;

  initial begin
    reset = 1; start = 0; in_valid = 0; sig_ack = 0; in_data = '0;
    tick(); chk_en = 1; tick();
    chk("rst_count", 32'(cnt[3]), 0);
    chk("rst_sig", sig[3], 0);
    chk("rst_ready", 32'(rdy[3]), 0);
    chk("rst_valid", 32'(sv[3]), 0);
    reset = 0;

    // T1: single vector, NVEC=1
    start = 1; tick(); start = 0;
    in_valid = 1; in_data = 128'h1; tick(); in_valid = 0;
    chk("T1_sig", sig[0], 32'h0000_0001);
    chk("T1_valid", 32'(sv[0]), 1);
    chk("T1_count", 32'(cnt[0]), 1);

    // T2: all-ones folds to zero, then a bit in the top slice
    do_reset();
    start = 1; tick(); start = 0;
    in_valid = 1; in_data = '1; tick();
    chk("T2_mid", sig[1], 32'h0);
    chk("T2_midcnt", 32'(cnt[1]), 1);
    in_data = 128'h1 << 96; tick(); in_valid = 0;
    chk("T2_final", sig[1], 32'h0000_0001);
    chk("T2_valid", 32'(sv[1]), 1);

    // T3: MSB feeds back and is shifted out
    do_reset();
    start = 1; tick(); start = 0;
    in_valid = 1; in_data = 128'h8000_0000; tick();
    chk("T3_mid", sig[1], 32'h8000_0000);
    in_data = '0; tick(); in_valid = 0;
    chk("T3_final", sig[1], 32'h0000_0001);

    // T4: valid held in IDLE, alternating in ACCUM, held in DONE
    do_reset();
    in_valid = 1; in_data = rnd128();
    repeat (3) tick();
    chk("T4_idle_cnt", 32'(cnt[2]), 0);
    chk("T4_idle_rdy", 32'(rdy[2]), 0);
    start = 1; tick(); start = 0;
    chk("T4_start_cnt", 32'(cnt[2]), 0);
    for (int k = 0; k < 8; k++) begin
      in_valid = (k % 2 == 0); in_data = rnd128(); tick();
    end
    in_valid = 1; repeat (3) tick();
    chk("T4_done_cnt", 32'(cnt[2]), 4);
    chk("T4_done_valid", 32'(sv[2]), 1);
    chk("T4_done_rdy", 32'(rdy[2]), 0);
    in_valid = 0; sig_ack = 1; tick(); sig_ack = 0;
    chk("T4_ack_valid", 32'(sv[2]), 0);

    // T5: reset mid-ACCUM, then a clean run of the same four vectors
    for (int k = 0; k < 4; k++) d5[k] = rnd128();
    do_reset();
    start = 1; tick(); start = 0;
    for (int k = 0; k < 2; k++) begin in_valid = 1; in_data = d5[k]; tick(); end
    in_valid = 0; do_reset();
    chk("T5_rst_sig", sig[2], 0);
    chk("T5_rst_cnt", 32'(cnt[2]), 0);
    chk("T5_rst_rdy", 32'(rdy[2]), 0);
    start = 1; tick(); start = 0;
    for (int k = 0; k < 4; k++) begin in_valid = 1; in_data = d5[k]; tick(); end
    in_valid = 0;
    ref5 = SEED;
    for (int k = 0; k < 4; k++) ref5 = misr_step(ref5, fold128(d5[k]));
    chk("T5_sig", sig[2], ref5);

    // T6: start mid-ACCUM ignored; start+ack in DONE takes only the ack
    do_reset();
    start = 1; tick(); start = 0;
    for (int k = 0; k < 2; k++) begin in_valid = 1; in_data = rnd128(); tick(); end
    in_valid = 0; start = 1; tick(); start = 0;
    chk("T6_mid_cnt", 32'(cnt[2]), 2);
    chk("T6_mid_busy", 32'(bsy[2]), 1);
    for (int k = 0; k < 2; k++) begin in_valid = 1; in_data = rnd128(); tick(); end
    in_valid = 0;
    chk("T6_done", 32'(sv[2]), 1);
    start = 1; sig_ack = 1; tick(); start = 0; sig_ack = 0;
    chk("T6_idle_rdy", 32'(rdy[2]), 0);
    chk("T6_idle_valid", 32'(sv[2]), 0);
    tick();
    chk("T6_still_idle", 32'(bsy[2]), 0);
    start = 1; tick(); start = 0;
    chk("T6_restart_rdy", 32'(rdy[2]), 1);
    chk("T6_restart_cnt", 32'(cnt[2]), 0);
    chk("T6_restart_sig", sig[2], SEED);

    // Random traffic, checked cycle by cycle by the model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      reset    = ($urandom % 400 == 0);
      start    = ($urandom % 6 == 0);
      in_valid = ($urandom % 4 != 0);
      sig_ack  = ($urandom % 3 == 0);
      in_data  = rnd128();
      tick();
    end
    reset = 0; start = 0; in_valid = 0; sig_ack = 0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
